dds_load_sequencer: RTL and testbench

//  Sequencer that configures and runs the multi-channel DDS core (theta/delta/ampl shift-register FIFOs).

---
 rtl/dds_load_sequencer.sv | 140 ++++++++++++++
 tb/tb_dds_load_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dds_load_sequencer.sv
// rtl/dds_load_sequencer.sv - replays a theta/delta/ampl shadow bank into the DDS FIFOs, then runs the core
module dds_load_sequencer #(
  parameter int SIG_WIDTH = 16,
  parameter int N_CH      = 4,
  parameter int CH_W      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  input  logic [1:0]           i_wr_sel,
  input  logic [CH_W-1:0]      i_wr_ch,
  input  logic [SIG_WIDTH-1:0] i_wr_data,
  input  logic                 i_commit,
  input  logic                 i_stop,
  output logic                 o_dds_rst,
  output logic                 o_dds_start,
  output logic [1:0]           o_dds_addrs,
  output logic [SIG_WIDTH-1:0] o_dds_fifo_data,
  output logic                 o_busy,
  output logic                 o_running
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD_THETA,
    ST_LOAD_DELTA,
    ST_LOAD_AMPL,
    ST_RUN
  } state_t;

  state_t                state, state_nxt;
  logic [CH_W-1:0]       ch, ch_nxt;
  logic [SIG_WIDTH-1:0]  bank [0:2][0:N_CH-1];

  logic                  dds_rst_nxt, start_nxt, busy_nxt, running_nxt, ready_nxt;
  logic [1:0]            addrs_nxt;
  logic [SIG_WIDTH-1:0]  data_nxt;
  logic                  loading;
  logic [1:0]            load_sel;
  logic                  last_ch;
  logic                  wr_en;

  // Reserved selector and out-of-range channels are handshaken but dropped.
  assign wr_en   = i_wr_valid && o_wr_ready && (i_wr_sel != 2'd3) && (int'(i_wr_ch) < N_CH);
  assign last_ch = (ch == CH_W'(N_CH - 1));

  always_comb begin
    state_nxt   = state;
    ch_nxt      = ch;
    dds_rst_nxt = 1'b0;
    start_nxt   = 1'b0;
    busy_nxt    = 1'b0;
    running_nxt = 1'b0;
    ready_nxt   = 1'b0;
    addrs_nxt   = 2'd0;
    data_nxt    = '0;
    loading     = 1'b0;
    load_sel    = 2'd0;

    case (state)
      ST_IDLE: begin
        dds_rst_nxt = 1'b1;
        ready_nxt   = 1'b1;
        if (i_commit) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        dds_rst_nxt = 1'b1;
        busy_nxt    = 1'b1;
        ch_nxt      = '0;
        state_nxt   = ST_LOAD_THETA;
      end
      ST_LOAD_THETA: begin
        loading  = 1'b1;
        load_sel = 2'd0;
        if (last_ch) state_nxt = ST_LOAD_DELTA;
      end
      ST_LOAD_DELTA: begin
        loading  = 1'b1;
        load_sel = 2'd1;
        if (last_ch) state_nxt = ST_LOAD_AMPL;
      end
      ST_LOAD_AMPL: begin
        loading  = 1'b1;
        load_sel = 2'd2;
        if (last_ch) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        start_nxt   = 1'b1;
        running_nxt = 1'b1;
        ready_nxt   = 1'b1;
        if (i_commit) state_nxt = ST_CLEAR;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Channel 0 is shifted first so it ends up at the FIFO output.
    if (loading) begin
      busy_nxt  = 1'b1;
      addrs_nxt = load_sel;
      data_nxt  = bank[load_sel][ch];
      ch_nxt    = last_ch ? '0 : ch + 1'b1;
    end

    if (i_stop) begin
      state_nxt = ST_IDLE;
      ch_nxt    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      ch              <= '0;
      o_dds_rst       <= 1'b1;
      o_dds_start     <= 1'b0;
      o_dds_addrs     <= 2'd0;
      o_dds_fifo_data <= '0;
      o_busy          <= 1'b0;
      o_running       <= 1'b0;
      o_wr_ready      <= 1'b1;
      for (int s = 0; s < 3; s++)
        for (int c = 0; c < N_CH; c++)
          bank[s][c] <= '0;
    end else begin
      state           <= state_nxt;
      ch              <= ch_nxt;
      o_dds_rst       <= dds_rst_nxt;
      o_dds_start     <= start_nxt;
      o_dds_addrs     <= addrs_nxt;
      o_dds_fifo_data <= data_nxt;
      o_busy          <= busy_nxt;
      o_running       <= running_nxt;
      o_wr_ready      <= ready_nxt;
      if (wr_en) bank[i_wr_sel][i_wr_ch] <= i_wr_data;
    end
  end

endmodule

// File: tb/tb_dds_load_sequencer.sv
// tb/tb_dds_load_sequencer.sv - directed table, corner sequences and random run against a step-count model
module tb_dds_load_sequencer;
  localparam int SW   = 16;
  localparam int N    = 4;
  localparam int CW   = 2;
  localparam int RUNK = 3 * N + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_wr_valid;
  logic          o_wr_ready;
  logic [1:0]    i_wr_sel;
  logic [CW-1:0] i_wr_ch;
  logic [SW-1:0] i_wr_data;
  logic          i_commit;
  logic          i_stop;
  logic          o_dds_rst;
  logic          o_dds_start;
  logic [1:0]    o_dds_addrs;
  logic [SW-1:0] o_dds_fifo_data;
  logic          o_busy;
  logic          o_running;

  always #5 clk = ~clk;

  dds_load_sequencer #(.SIG_WIDTH(SW), .N_CH(N), .CH_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_wr_valid      (i_wr_valid),
    .o_wr_ready      (o_wr_ready),
    .i_wr_sel        (i_wr_sel),
    .i_wr_ch         (i_wr_ch),
    .i_wr_data       (i_wr_data),
    .i_commit        (i_commit),
    .i_stop          (i_stop),
    .o_dds_rst       (o_dds_rst),
    .o_dds_start     (o_dds_start),
    .o_dds_addrs     (o_dds_addrs),
    .o_dds_fifo_data (o_dds_fifo_data),
    .o_busy          (o_busy),
    .o_running       (o_running)
  );

  int errors = 0;
  int checks = 0;

  // Model: m_cur = -1 idle, 0 clear, 1..3N load word k, RUNK run.
  logic [SW-1:0] m_bank [3][N];
  int            m_cur = -1;
  logic          e_rst = 1'b1, e_start = 1'b0, e_busy = 1'b0, e_running = 1'b0, e_ready = 1'b1;
  logic [1:0]    e_addrs = 2'd0;
  logic [SW-1:0] e_data = '0;

  typedef struct {
    logic          commit;
    logic          stop;
    logic          e_rst;
    logic          e_start;
    logic [1:0]    e_addrs;
    logic [SW-1:0] e_data;
    logic          e_busy;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input logic c, input logic s, input logic r, input logic st,
                              input logic [1:0] a, input logic [SW-1:0] d, input logic b);
    vec_t v;
    v.commit = c; v.stop = s; v.e_rst = r; v.e_start = st;
    v.e_addrs = a; v.e_data = d; v.e_busy = b;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic acc;
    int   k;
    if (rst) begin
      for (int s = 0; s < 3; s++)
        for (int c = 0; c < N; c++)
          m_bank[s][c] = '0;
      m_cur = -1;
      e_rst = 1'b1; e_start = 1'b0; e_addrs = 2'd0; e_data = '0;
      e_busy = 1'b0; e_running = 1'b0; e_ready = 1'b1;
      return;
    end
    acc = e_ready && i_wr_valid && (i_wr_sel != 2'd3) && (int'(i_wr_ch) < N);
    e_rst = 1'b0; e_start = 1'b0; e_addrs = 2'd0; e_data = '0;
    e_busy = 1'b0; e_running = 1'b0; e_ready = 1'b0;
    if (m_cur < 0) begin
      e_rst = 1'b1; e_ready = 1'b1;
    end else if (m_cur == 0) begin
      e_rst = 1'b1; e_busy = 1'b1;
    end else if (m_cur < RUNK) begin
      k = m_cur - 1;
      e_addrs = 2'(k / N);
      e_data  = m_bank[k / N][k % N];
      e_busy  = 1'b1;
    end else begin
      e_start = 1'b1; e_running = 1'b1; e_ready = 1'b1;
    end
    if (acc) m_bank[i_wr_sel][i_wr_ch] = i_wr_data;
    if (i_stop) m_cur = -1;
    else if (i_commit && (m_cur < 0 || m_cur == RUNK)) m_cur = 0;
    else if (m_cur >= 0 && m_cur < RUNK) m_cur++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model", 64'({o_dds_rst, o_dds_start, o_dds_addrs, o_dds_fifo_data, o_busy, o_running, o_wr_ready}),
                   64'({e_rst, e_start, e_addrs, e_data, e_busy, e_running, e_ready}));
  endtask

  task automatic write(input logic [1:0] sel, input logic [CW-1:0] ch, input logic [SW-1:0] data);
    i_wr_valid = 1'b1; i_wr_sel = sel; i_wr_ch = ch; i_wr_data = data;
    step();
    i_wr_valid = 1'b0;
  endtask

  task automatic run_table(input int extra_at);
    for (int i = 0; i < 15; i++) begin
      i_commit = tbl[i].commit | (i == extra_at);
      i_stop   = tbl[i].stop;
      step();
      check($sformatf("table%0d", i),
            64'({o_dds_rst, o_dds_start, o_dds_addrs, o_dds_fifo_data, o_busy}),
            64'({tbl[i].e_rst, tbl[i].e_start, tbl[i].e_addrs, tbl[i].e_data, tbl[i].e_busy}));
    end
    i_commit = 1'b0;
    i_stop   = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tbl[2 + i]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'(32'h0100 * i + 1), 1'b1);
      tbl[6 + i]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 16'h0010, 1'b1);
      tbl[10 + i] = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 16'h7FFF, 1'b1);
    end
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0000, 1'b0);

    rst = 1'b1; i_wr_valid = 1'b0; i_wr_sel = 2'd0; i_wr_ch = '0; i_wr_data = '0;
    i_commit = 1'b0; i_stop = 1'b0;
    step();
    step();
    check("reset_state", 64'({o_dds_rst, o_dds_start, o_busy, o_running, o_wr_ready}), 64'(5'b10001));
    rst = 1'b0;
    step();

    for (int c = 0; c < N; c++) begin
      write(2'd0, CW'(c), 16'(32'h0100 * c + 1));
      write(2'd1, CW'(c), 16'h0010);
      write(2'd2, CW'(c), 16'h7FFF);
    end
    write(2'd3, 2'd0, 16'hDEAD);

    run_table(-1);

    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    step();
    run_table(6);

    write(2'd1, 2'd2, 16'h0040);
    i_commit = 1'b1;
    step();
    i_commit = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("reload_delta2", 64'({o_dds_addrs, o_dds_fifo_data}), 64'({2'd1, 16'h0040}));
    for (int i = 0; i < 6; i++) step();
    check("reload_run", 64'({o_dds_start, o_running, o_busy}), 64'(3'b110));

    i_stop = 1'b1; i_commit = 1'b1;
    step();
    i_stop = 1'b0; i_commit = 1'b0;
    step();
    check("stop_wins", 64'({o_dds_rst, o_dds_start, o_busy, o_running}), 64'(4'b1000));
    step();
    check("stop_no_clear", 64'({o_dds_rst, o_busy}), 64'(2'b10));

    i_commit = 1'b1;
    step();
    i_commit = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("in_ampl", 64'({o_dds_addrs, o_busy}), 64'({2'd2, 1'b1}));
    rst = 1'b1;
    step();
    check("rst_midload", 64'({o_dds_rst, o_dds_start, o_dds_addrs, o_busy, o_running, o_wr_ready}),
                         64'({1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1}));
    rst = 1'b0;
    step();
    i_commit = 1'b1;
    step();
    i_commit = 1'b0;
    for (int i = 0; i < 2; i++) step();
    check("zero_theta0", 64'({o_dds_addrs, o_dds_fifo_data, o_busy}), 64'({2'd0, 16'h0000, 1'b1}));
    for (int i = 0; i < 12; i++) step();
    check("zero_run", 64'({o_dds_start, o_running}), 64'(2'b11));

    for (int n = 0; n < 800; n++) begin
      rst        = ($urandom_range(99) == 0);
      i_wr_valid = $urandom_range(1);
      i_wr_sel   = 2'($urandom_range(3));
      i_wr_ch    = CW'($urandom_range(N - 1));
      i_wr_data  = 16'($urandom);
      i_commit   = ($urandom_range(15) == 0);
      i_stop     = ($urandom_range(39) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
